// File: rtl/gpr_wr_arb.sv
// gpr_wr_arb: round-robin arbiter for the single GPR-file write port.
// Requester 0 is the main writeback stage; 1..N_REQ-1 are long-latency units.
// The granted write is registered and reaches the GPR file one cycle later.
// Writes to x0 complete their handshake but never assert o_gpr_wr_en.
// Optional macro GPR_WR_ARB_FWD_EN adds same-cycle write-to-read forwarding ports.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif

module gpr_wr_arb #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int GPRS_WIDTH = `GPRS_WIDTH,
    parameter int N_REQ      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req_valid,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic [N_REQ*GPRS_WIDTH-1:0] i_req_id,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic                        o_gpr_wr_en,
    output logic [GPRS_WIDTH-1:0]       o_gpr_wr_id,
    output logic [DATA_WIDTH-1:0]       o_gpr_wr_data,
`ifdef GPR_WR_ARB_FWD_EN
    input  logic [GPRS_WIDTH-1:0]       i_fwd_rs1_id,
    input  logic [GPRS_WIDTH-1:0]       i_fwd_rs2_id,
    output logic                        o_fwd_rs1_hit,
    output logic                        o_fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0]       o_fwd_rs1_data,
    output logic [DATA_WIDTH-1:0]       o_fwd_rs2_data,
`endif
    output logic                        o_busy
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      ptr_next;
    logic                  gnt_any;
    logic [N_REQ-1:0]      gnt_vec;
    logic [GPRS_WIDTH-1:0] gnt_id;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_writes;

    // Round-robin pick: the modular search from rr_ptr is split into two
    // ascending passes (k >= rr_ptr, then any k) so every index is constant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!gnt_any && i_req_valid[k] && (32'(rr_ptr) <= k)) begin
                gnt_any    = 1'b1;
                gnt_idx    = PTR_W'(k);
                gnt_vec[k] = 1'b1;
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!gnt_any && i_req_valid[k]) begin
                gnt_any    = 1'b1;
                gnt_idx    = PTR_W'(k);
                gnt_vec[k] = 1'b1;
            end
        end
    end

    // One-hot mux of the granted requester's id and data.
    always_comb begin
        gnt_id   = '0;
        gnt_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_vec[k]) begin
                gnt_id   = i_req_id[k*GPRS_WIDTH +: GPRS_WIDTH];
                gnt_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Handshake, next pointer and x0 filter.
    always_comb begin
        o_req_ready = i_rst ? '0 : gnt_vec;
        ptr_next    = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        gnt_writes  = gnt_any && (gnt_id != '0);
    end

    // Round-robin pointer: moves past the last granted requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= ptr_next;
        end
    end

    // Output register stage; id/data hold when nothing is written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gpr_wr_en   <= 1'b0;
            o_gpr_wr_id   <= '0;
            o_gpr_wr_data <= '0;
        end else begin
            o_gpr_wr_en <= gnt_writes;
            if (gnt_writes) begin
                o_gpr_wr_id   <= gnt_id;
                o_gpr_wr_data <= gnt_data;
            end
        end
    end

    // Busy while any request is pending or a write is in flight.
    always_comb begin
        o_busy = (|i_req_valid) || o_gpr_wr_en;
    end

`ifdef GPR_WR_ARB_FWD_EN
    // Forward the write in flight to readers of the same register this cycle.
    always_comb begin
        o_fwd_rs1_hit  = o_gpr_wr_en && (i_fwd_rs1_id == o_gpr_wr_id) && (i_fwd_rs1_id != '0);
        o_fwd_rs2_hit  = o_gpr_wr_en && (i_fwd_rs2_id == o_gpr_wr_id) && (i_fwd_rs2_id != '0);
        o_fwd_rs1_data = o_fwd_rs1_hit ? o_gpr_wr_data : '0;
        o_fwd_rs2_data = o_fwd_rs2_hit ? o_gpr_wr_data : '0;
    end
`endif

endmodule
